// File: rtl/uart_transmitter.sv
// 8-N-1 UART transmitter with a registered serial line, busy flag and done pulse.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    // Frame sequencer; tx is loaded one edge ahead so it stays a clean flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        shreg   <= tx_byte;
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_byte;
`endif
                    end
                end

                START: begin
                    if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        tx    <= shreg[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif

                STOP: begin
                    tx <= 1'b1;
                    if (cnt == CNT_MAX) begin
                        cnt     <= '0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
